// File: rtl/code_mem_loader.sv
`default_nettype none
// ============================================================================
// Module      : code_mem_loader
// Description : Assembles 64-bit instructions from a 32-bit AXI-Stream-style
//               beat stream (big-endian pairs: high word first) and writes
//               them sequentially into the packet-filter code memory.
//               A program ends at S_TLAST. A complete program pulses
//               load_done together with its final write and updates
//               instr_count. An odd-length program or a program that
//               overflows the code memory pulses load_err instead.
//
// Ports       : clk              - single clock, rising edge
//               rst              - synchronous active-high reset
//               S_TDATA[31:0]    - half-instruction beat
//               S_TVALID         - beat valid
//               S_TREADY         - loader can accept a beat
//               S_TLAST          - final beat of a program
//               code_mem_wr_addr - instruction write address
//               code_mem_wr_data - assembled instruction
//               code_mem_wr_en   - one-cycle write strobe
//               load_done        - one-cycle pulse, program loaded
//               load_err         - one-cycle pulse, program rejected
//               instr_count      - instruction count of last good program
//
// Revision    : 1.0 - initial release
// ============================================================================
module code_mem_loader #(
    parameter int CODE_ADDR_WIDTH = 10,
    parameter int CODE_DATA_WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [31:0]                S_TDATA,
    input  logic                       S_TVALID,
    output logic                       S_TREADY,
    input  logic                       S_TLAST,
    output logic [CODE_ADDR_WIDTH-1:0] code_mem_wr_addr,
    output logic [CODE_DATA_WIDTH-1:0] code_mem_wr_data,
    output logic                       code_mem_wr_en,
    output logic                       load_done,
    output logic                       load_err,
    output logic [CODE_ADDR_WIDTH:0]   instr_count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,   // expecting the high word of an instruction
        ST_HI    = 2'd1,   // high word held, expecting the low word
        ST_DRAIN = 2'd2    // program rejected, discarding up to TLAST
    } state_t;

    localparam logic [CODE_ADDR_WIDTH:0] c_PTR_ONE = {{CODE_ADDR_WIDTH{1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t                       r_state;
    logic [CODE_ADDR_WIDTH:0]     r_ptr;
    logic [31:0]                  r_hi;
    logic                         r_ready;
    logic                         r_wr_en;
    logic [CODE_ADDR_WIDTH-1:0]   r_wr_addr;
    logic [CODE_DATA_WIDTH-1:0]   r_wr_data;
    logic                         r_done;
    logic                         r_err;
    logic [CODE_ADDR_WIDTH:0]     r_cnt;

    // ------------------------------------------------------------------
    // Next-state wires
    // ------------------------------------------------------------------
    state_t                       w_state_nxt;
    logic [CODE_ADDR_WIDTH:0]     w_ptr_nxt;
    logic [31:0]                  w_hi_nxt;
    logic                         w_wr_en_nxt;
    logic [CODE_ADDR_WIDTH-1:0]   w_wr_addr_nxt;
    logic [CODE_DATA_WIDTH-1:0]   w_wr_data_nxt;
    logic                         w_done_nxt;
    logic                         w_err_nxt;
    logic [CODE_ADDR_WIDTH:0]     w_cnt_nxt;
    logic [CODE_ADDR_WIDTH:0]     w_ptr_inc;
    logic                         w_accept;
    logic                         w_mem_full;

    // r_ready is cleared by reset and only re-armed one edge after reset
    // releases, so the stream is stalled for the first post-reset cycle.
    // Gating with rst keeps the stall visible from the moment rst rises.
    assign S_TREADY   = r_ready & ~rst;
    assign w_accept   = S_TVALID & S_TREADY;
    assign w_ptr_inc  = r_ptr + c_PTR_ONE;
    // Pointer MSB set means every code memory location has been written.
    assign w_mem_full = r_ptr[CODE_ADDR_WIDTH];

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_hi_nxt      = r_hi;
        w_wr_en_nxt   = 1'b0;
        w_wr_addr_nxt = r_wr_addr;
        w_wr_data_nxt = r_wr_data;
        w_done_nxt    = 1'b0;
        w_err_nxt     = 1'b0;
        w_cnt_nxt     = r_cnt;

        if (w_accept) begin
            case (r_state)
                ST_IDLE: begin
                    if (S_TLAST) begin
                        // Program ended on a high word: odd length.
                        w_err_nxt = 1'b1;
                        w_ptr_nxt = '0;
                    end else begin
                        w_hi_nxt    = S_TDATA;
                        w_state_nxt = ST_HI;
                    end
                end

                ST_HI: begin
                    if (w_mem_full) begin
                        // Pair completed with no room left: never written.
                        if (S_TLAST) begin
                            w_err_nxt   = 1'b1;
                            w_ptr_nxt   = '0;
                            w_state_nxt = ST_IDLE;
                        end else begin
                            w_state_nxt = ST_DRAIN;
                        end
                    end else begin
                        w_wr_en_nxt   = 1'b1;
                        w_wr_addr_nxt = r_ptr[CODE_ADDR_WIDTH-1:0];
                        w_wr_data_nxt = {r_hi, S_TDATA};
                        w_state_nxt   = ST_IDLE;
                        if (S_TLAST) begin
                            w_done_nxt = 1'b1;
                            w_cnt_nxt  = w_ptr_inc;
                            w_ptr_nxt  = '0;
                        end else begin
                            w_ptr_nxt  = w_ptr_inc;
                        end
                    end
                end

                ST_DRAIN: begin
                    if (S_TLAST) begin
                        w_err_nxt   = 1'b1;
                        w_ptr_nxt   = '0;
                        w_state_nxt = ST_IDLE;
                    end
                end

                default: begin
                    w_state_nxt = ST_IDLE;
                    w_ptr_nxt   = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_ptr     <= '0;
            r_hi      <= '0;
            r_ready   <= 1'b0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_hi      <= w_hi_nxt;
            r_ready   <= 1'b1;
            r_wr_en   <= w_wr_en_nxt;
            r_wr_addr <= w_wr_addr_nxt;
            r_wr_data <= w_wr_data_nxt;
            r_done    <= w_done_nxt;
            r_err     <= w_err_nxt;
            r_cnt     <= w_cnt_nxt;
        end
    end

    assign code_mem_wr_en   = r_wr_en;
    assign code_mem_wr_addr = r_wr_addr;
    assign code_mem_wr_data = r_wr_data;
    assign load_done        = r_done;
    assign load_err         = r_err;
    assign instr_count      = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_code_mem_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_code_mem_loader
// Description : Self-checking bench for code_mem_loader (CODE_ADDR_WIDTH=2).
//               Beats come from a vector table; each beat that should cause
//               a write or an error pushes an expected event, stamped with
//               the cycle it must appear in, onto a scoreboard queue that a
//               negedge monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_code_mem_loader;

    localparam int TB_AW = 2;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [31:0]        S_TDATA;
    logic               S_TVALID;
    logic               S_TREADY;
    logic               S_TLAST;
    logic [TB_AW-1:0]   code_mem_wr_addr;
    logic [63:0]        code_mem_wr_data;
    logic               code_mem_wr_en;
    logic               load_done;
    logic               load_err;
    logic [TB_AW:0]     instr_count;

    code_mem_loader #(
        .CODE_ADDR_WIDTH (TB_AW),
        .CODE_DATA_WIDTH (64)
    ) u_dut (
        .clk              (clk),
        .rst              (rst),
        .S_TDATA          (S_TDATA),
        .S_TVALID         (S_TVALID),
        .S_TREADY         (S_TREADY),
        .S_TLAST          (S_TLAST),
        .code_mem_wr_addr (code_mem_wr_addr),
        .code_mem_wr_data (code_mem_wr_data),
        .code_mem_wr_en   (code_mem_wr_en),
        .load_done        (load_done),
        .load_err         (load_err),
        .instr_count      (instr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]      data;
        logic             last;
        int               gap;
        logic             ev_wr;
        logic             ev_err;
        logic [TB_AW-1:0] addr;
        logic [63:0]      wdata;
        logic             done;
        logic             chk_cnt;
        logic [TB_AW:0]   cnt;
    } vec_t;

    typedef struct {
        int               stamp;
        logic             is_err;
        logic [TB_AW-1:0] addr;
        logic [63:0]      wdata;
        logic             done;
    } exp_t;

    vec_t tbl[$];
    vec_t prog_a[$];
    exp_t sb[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // kind: 0 no event, 1 write, 2 write + load_done, 3 load_err
    // c   : expected instr_count after this beat, or -1 for no check
    function automatic vec_t mk(input logic [31:0] d, input int l, input int k,
                                input int a, input logic [63:0] wd, input int c);
        vec_t v;
        v.data    = d;
        v.last    = (l != 0);
        v.gap     = 0;
        v.ev_wr   = (k == 1) || (k == 2);
        v.done    = (k == 2);
        v.ev_err  = (k == 3);
        v.addr    = a[TB_AW-1:0];
        v.wdata   = wd;
        v.chk_cnt = (c >= 0);
        v.cnt     = (c >= 0) ? c[TB_AW:0] : '0;
        return v;
    endfunction

    // Present one beat, wait (bounded) for acceptance, push its expected
    // event stamped for the cycle following the accepting edge.
    task automatic drive(input vec_t v);
        exp_t e;
        int   tries;
        if (v.gap > 0) repeat (v.gap) @(negedge clk);
        S_TDATA  = v.data;
        S_TLAST  = v.last;
        S_TVALID = 1'b1;
        tries    = 0;
        while (!S_TREADY && tries < 20) begin
            @(negedge clk);
            tries++;
        end
        check("tready_accept", 64'(S_TREADY), 64'd1);
        if (!S_TREADY) begin
            S_TVALID = 1'b0;
            return;
        end
        @(posedge clk);
        if (v.ev_wr || v.ev_err) begin
            e.stamp  = cyc + 1;
            e.is_err = v.ev_err;
            e.addr   = v.addr;
            e.wdata  = v.wdata;
            e.done   = v.done;
            sb.push_back(e);
        end
        @(negedge clk);
        S_TVALID = 1'b0;
        if (v.chk_cnt) check("instr_count", 64'(instr_count), 64'(v.cnt));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tready"},  64'(S_TREADY),         64'd0);
        check({tag, "_wr_en"},   64'(code_mem_wr_en),   64'd0);
        check({tag, "_wr_addr"}, 64'(code_mem_wr_addr), 64'd0);
        check({tag, "_wr_data"}, code_mem_wr_data,      64'd0);
        check({tag, "_done"},    64'(load_done),        64'd0);
        check({tag, "_err"},     64'(load_err),         64'd0);
        check({tag, "_count"},   64'(instr_count),      64'd0);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        while (sb.size() > 0 && sb[0].stamp < cyc) begin
            e = sb.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL missed_event: expected at cycle %0d (err=%b addr=%0d) but it did not occur", e.stamp, e.is_err, e.addr);
        end
        if (code_mem_wr_en || load_done || load_err) begin
            if (sb.size() == 0 || sb[0].stamp != cyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_event: cycle %0d wr_en=%b done=%b err=%b addr=%0d, expected none",
                         cyc, code_mem_wr_en, load_done, load_err, code_mem_wr_addr);
            end else begin
                e = sb.pop_front();
                check("ev_wr_en", 64'(code_mem_wr_en), 64'(!e.is_err));
                check("ev_load_err", 64'(load_err), 64'(e.is_err));
                check("ev_load_done", 64'(load_done), 64'(e.done));
                if (!e.is_err) begin
                    check("ev_wr_addr", 64'(code_mem_wr_addr), 64'(e.addr));
                    check("ev_wr_data", code_mem_wr_data, e.wdata);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] hi;
        logic [31:0] lo;
        vec_t        v;

        S_TDATA  = '0;
        S_TVALID = 1'b0;
        S_TLAST  = 1'b0;
        rst      = 1'b1;

        // Basic two-instruction program
        prog_a.push_back(mk(32'h00280000, 0, 0, 0, 64'h0, -1));
        prog_a.push_back(mk(32'h0000000C, 0, 1, 0, 64'h002800000000000C, -1));
        prog_a.push_back(mk(32'h00060000, 0, 0, 0, 64'h0, -1));
        prog_a.push_back(mk(32'h0000FFFF, 1, 2, 1, 64'h000600000000FFFF, 2));

        foreach (prog_a[i]) tbl.push_back(prog_a[i]);
        // Three-beat program: one write, then error, count unchanged
        tbl.push_back(mk(32'h11111111, 0, 0, 0, 64'h0, -1));
        tbl.push_back(mk(32'h22222222, 0, 1, 0, 64'h1111111122222222, -1));
        tbl.push_back(mk(32'h33333333, 1, 3, 0, 64'h0, 2));
        // Single-beat program, then a one-instruction program from addr 0
        tbl.push_back(mk(32'hAAAAAAAA, 1, 3, 0, 64'h0, 2));
        tbl.push_back(mk(32'h12345678, 0, 0, 0, 64'h0, -1));
        tbl.push_back(mk(32'h9ABCDEF0, 1, 2, 0, 64'h123456789ABCDEF0, 1));
        // Five instructions into a four-deep memory, TLAST on the fifth
        for (int i = 0; i < 5; i++) begin
            hi = 32'hA0000000 | i;
            lo = 32'h00000B00 | i;
            tbl.push_back(mk(hi, 0, 0, 0, 64'h0, -1));
            tbl.push_back(mk(lo, (i == 4) ? 1 : 0, (i < 4) ? 1 : 3, i, {hi, lo}, (i == 4) ? 1 : -1));
        end
        // Exactly-full program
        for (int i = 0; i < 4; i++) begin
            hi = 32'hC0000000 | i;
            lo = 32'hD0000000 | i;
            tbl.push_back(mk(hi, 0, 0, 0, 64'h0, -1));
            tbl.push_back(mk(lo, (i == 3) ? 1 : 0, (i == 3) ? 2 : 1, i, {hi, lo}, (i == 3) ? 4 : -1));
        end
        // Overflow without TLAST: drain two more beats before the error
        for (int i = 0; i < 5; i++) begin
            hi = 32'h50000000 | i;
            lo = 32'h60000000 | i;
            tbl.push_back(mk(hi, 0, 0, 0, 64'h0, -1));
            tbl.push_back(mk(lo, 0, (i < 4) ? 1 : 0, i, {hi, lo}, -1));
        end
        tbl.push_back(mk(32'hE0000000, 0, 0, 0, 64'h0, -1));
        tbl.push_back(mk(32'hE0000001, 1, 3, 0, 64'h0, 4));
        // Two back-to-back programs
        foreach (prog_a[i]) tbl.push_back(prog_a[i]);
        foreach (prog_a[i]) tbl.push_back(prog_a[i]);

        // Reset state
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        rst = 1'b0;
        #1;
        check("tready_post_rst_cycle", 64'(S_TREADY), 64'd0);
        @(negedge clk);
        check("tready_after_rst", 64'(S_TREADY), 64'd1);

        for (int i = 0; i < tbl.size(); i++) drive(tbl[i]);

        // Random valid gaps over the basic program
        for (int i = 0; i < prog_a.size(); i++) begin
            v     = prog_a[i];
            v.gap = int'($urandom_range(0, 3));
            drive(v);
        end

        // Reset with a high word held; a beat offered during and right
        // after reset must not be taken.
        drive(mk(32'h00280000, 0, 0, 0, 64'h0, -1));
        rst      = 1'b1;
        S_TDATA  = 32'hDEADBEEF;
        S_TLAST  = 1'b0;
        S_TVALID = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs("mid");
        rst = 1'b0;
        #1;
        check("tready_post_mid_rst", 64'(S_TREADY), 64'd0);
        @(negedge clk);
        S_TVALID = 1'b0;
        foreach (prog_a[i]) drive(prog_a[i]);

        repeat (4) @(negedge clk);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
